// File: rtl/gpio_frame_fifo_if.sv
// Frame FIFO bus: capture/pop/clear controls and buffered head frame readout.
// Width parameters must match the gpio_frame_fifo instance they connect to.
interface gpio_frame_fifo_if #(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic                  tick_i;
  logic [31:0]           seq_i;
  logic [NUM_CH*32-1:0]  ch_i;
  logic                  pop_i;
  logic                  clear_i;
  logic                  valid_o;
  logic [31:0]           seq_o;
  logic [NUM_CH*32-1:0]  data_o;
  logic [LW-1:0]         level_o;
  logic                  overflow_o;
  logic [15:0]           drop_count_o;

  modport master (
    output tick_i, seq_i, ch_i, pop_i, clear_i,
    input  valid_o, seq_o, data_o, level_o,
    input  overflow_o, drop_count_o
  );

  modport slave (
    input  tick_i, seq_i, ch_i, pop_i, clear_i,
    output valid_o, seq_o, data_o, level_o,
    output overflow_o, drop_count_o
  );
endinterface

// File: rtl/gpio_frame_fifo.sv
// Buffers {seq, channel words} frames per tick for polled GPIO readout.
// Define GPIO_FRAME_FIFO_DROP_CNT_EN to build the saturating drop counter.
module gpio_frame_fifo #(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 16
) (
  input  logic clk,
  input  logic reset,
  gpio_frame_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = 32 + NUM_CH * 32;

  logic [FW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          pop_q;
  logic          pop_ev;
  logic          armed;
  logic          overflow;
  logic          full;
  logic          do_pop;
  logic          do_wr;
  logic          drop;

  always_comb begin
    full   = (count == LW'(DEPTH));
    do_pop = pop_ev && (count != '0);
    do_wr  = bus.tick_i && (!full || do_pop);
    drop   = bus.tick_i && full && !do_pop;
  end

  // armed masks the first post-reset sample so a held pop_i never pops
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pop_q    <= 1'b0;
      pop_ev   <= 1'b0;
      armed    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      pop_q  <= bus.pop_i;
      armed  <= 1'b1;
      pop_ev <= armed & bus.pop_i & ~pop_q;
      if (do_wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + LW'(do_wr) - LW'(do_pop);
      if (drop)
        overflow <= 1'b1;
      else if (bus.clear_i)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wr_ptr] <= {bus.seq_i, bus.ch_i};
  end

`ifdef GPIO_FRAME_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      drop_cnt <= '0;
    else if (drop) begin
      if (bus.clear_i)
        drop_cnt <= 16'd1;
      else if (drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 1'b1;
    end else if (bus.clear_i)
      drop_cnt <= '0;
  end

  assign bus.drop_count_o = drop_cnt;
`else
  assign bus.drop_count_o = '0;
`endif

  assign bus.valid_o             = (count != '0);
  assign bus.level_o             = count;
  assign bus.overflow_o          = overflow;
  assign {bus.seq_o, bus.data_o} = mem[rd_ptr];
endmodule

// File: tb/tb_gpio_frame_fifo.sv
// Directed vector bench for gpio_frame_fifo (NUM_CH=4, DEPTH=16).
// Channel word k of a frame is seq*3+k, so ch0 equals seq*3.
module tb_gpio_frame_fifo;
  localparam int NUM_CH = 4;
  localparam int DEPTH  = 16;
`ifdef GPIO_FRAME_FIFO_DROP_CNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  typedef struct {
    bit tick;
    int seq;
    bit pop;
    bit valid;
    int level;
    int hseq;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vt[16];

  gpio_frame_fifo_if #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) bus ();

  gpio_frame_fifo #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [NUM_CH*32-1:0] mk(input int s);
    logic [NUM_CH*32-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_CH; k++)
      v[k*32 +: 32] = 32'(s * 3 + k);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string nm, input int s);
    chk({nm, ".valid"}, 128'(bus.valid_o), 128'(1));
    chk({nm, ".seq"}, 128'(bus.seq_o), 128'(s));
    chk({nm, ".data"}, 128'(bus.data_o), 128'(mk(s)));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst.level", 128'(bus.level_o), 128'(0));
    chk("rst.valid", 128'(bus.valid_o), 128'(0));
    chk("rst.ovf", 128'(bus.overflow_o), 128'(0));
    chk("rst.drop", 128'(bus.drop_count_o), 128'(0));
  endtask

  task automatic tick_seq(input int s);
    bus.tick_i = 1'b1;
    bus.seq_i  = 32'(s);
    bus.ch_i   = mk(s);
    step();
    bus.tick_i = 1'b0;
  endtask

  task automatic pop_one();
    bus.pop_i = 1'b1;
    step();
    bus.pop_i = 1'b0;
    step();
  endtask

  initial begin
    bus.tick_i  = 1'b0;
    bus.seq_i   = '0;
    bus.ch_i    = '0;
    bus.pop_i   = 1'b0;
    bus.clear_i = 1'b0;

    vt[0]  = '{1, 100, 0, 1, 1, 100};
    vt[1]  = '{1, 101, 0, 1, 2, 100};
    vt[2]  = '{1, 102, 0, 1, 3, 100};
    vt[3]  = '{1, 103, 0, 1, 4, 100};
    vt[4]  = '{1, 104, 0, 1, 5, 100};
    vt[5]  = '{0, 0, 1, 1, 5, 100};
    vt[6]  = '{0, 0, 0, 1, 4, 101};
    vt[7]  = '{0, 0, 1, 1, 4, 101};
    vt[8]  = '{0, 0, 0, 1, 3, 102};
    vt[9]  = '{0, 0, 1, 1, 3, 102};
    vt[10] = '{0, 0, 0, 1, 2, 103};
    vt[11] = '{0, 0, 1, 1, 2, 103};
    vt[12] = '{0, 0, 0, 1, 1, 104};
    vt[13] = '{0, 0, 1, 1, 1, 104};
    vt[14] = '{0, 0, 0, 0, 0, 0};
    vt[15] = '{0, 0, 0, 0, 0, 0};

    do_reset();

    for (int i = 0; i < 16; i++) begin
      bus.tick_i = vt[i].tick;
      bus.seq_i  = 32'(vt[i].seq);
      bus.ch_i   = mk(vt[i].seq);
      bus.pop_i  = vt[i].pop;
      step();
      chk($sformatf("fd%0d.valid", i), 128'(bus.valid_o),
          128'(vt[i].valid));
      chk($sformatf("fd%0d.level", i), 128'(bus.level_o),
          128'(vt[i].level));
      if (vt[i].valid)
        chk_head($sformatf("fd%0d", i), vt[i].hseq);
    end
    bus.tick_i = 1'b0;
    bus.pop_i  = 1'b0;

    do_reset();
    for (int s = 0; s < 20; s++) tick_seq(s);
    chk("ovf.level", 128'(bus.level_o), 128'(16));
    chk("ovf.flag", 128'(bus.overflow_o), 128'(1));
    chk("ovf.drop", 128'(bus.drop_count_o), 128'(CNT_EN * 4));
    for (int s = 0; s < 16; s++) begin
      chk_head($sformatf("ovf.h%0d", s), s);
      pop_one();
    end
    chk("ovf.empty", 128'(bus.level_o), 128'(0));

    do_reset();
    for (int s = 0; s < 16; s++) tick_seq(s);
    bus.pop_i = 1'b1;
    step();
    bus.pop_i = 1'b0;
    tick_seq(77);
    chk("sim.level", 128'(bus.level_o), 128'(16));
    chk("sim.ovf", 128'(bus.overflow_o), 128'(0));
    chk("sim.drop", 128'(bus.drop_count_o), 128'(0));
    for (int s = 1; s < 16; s++) begin
      chk_head($sformatf("sim.h%0d", s), s);
      pop_one();
    end
    chk_head("sim.last", 77);
    pop_one();
    chk("sim.empty", 128'(bus.valid_o), 128'(0));

    do_reset();
    for (int s = 0; s < 3; s++) tick_seq(40 + s);
    bus.pop_i = 1'b1;
    for (int i = 0; i < 10; i++) step();
    bus.pop_i = 1'b0;
    step();
    chk("hold.level", 128'(bus.level_o), 128'(2));
    chk_head("hold", 41);
    do_reset();
    pop_one();
    pop_one();
    chk("mtpop.level", 128'(bus.level_o), 128'(0));
    chk("mtpop.valid", 128'(bus.valid_o), 128'(0));

    do_reset();
    for (int s = 0; s < 16; s++) tick_seq(s);
    bus.clear_i = 1'b1;
    tick_seq(99);
    bus.clear_i = 1'b0;
    chk("cd.ovf", 128'(bus.overflow_o), 128'(1));
    chk("cd.drop", 128'(bus.drop_count_o), 128'(CNT_EN));
    chk("cd.level", 128'(bus.level_o), 128'(16));
    bus.clear_i = 1'b1;
    step();
    bus.clear_i = 1'b0;
    chk("clr.ovf", 128'(bus.overflow_o), 128'(0));
    chk("clr.drop", 128'(bus.drop_count_o), 128'(0));
    chk("clr.level", 128'(bus.level_o), 128'(16));
    chk_head("clr", 0);

    do_reset();
    for (int s = 0; s < 7; s++) tick_seq(200 + s);
    bus.pop_i = 1'b1;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rmid.level", 128'(bus.level_o), 128'(0));
    chk("rmid.valid", 128'(bus.valid_o), 128'(0));
    for (int i = 0; i < 3; i++) step();
    chk("rmid.idle", 128'(bus.level_o), 128'(0));
    tick_seq(500);
    chk("rmid.lvl1", 128'(bus.level_o), 128'(1));
    chk_head("rmid", 500);
    for (int i = 0; i < 4; i++) step();
    chk("rmid.nopop", 128'(bus.level_o), 128'(1));
    bus.pop_i = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
